// File: rtl/shift_id_ex_if.sv
// shift_id_ex_if: decode-side inputs, forwarding buses and execute-side outputs of the shift ID/EX stage
interface shift_id_ex_if #(
  parameter int DW = 16,
  parameter int RW = 4
);
  logic          in_valid;
  logic [DW-1:0] in_instr;
  logic [DW-1:0] in_rs_data;
  logic          stall;
  logic          flush;
  logic          fwd_exmem_en;
  logic [RW-1:0] fwd_exmem_rd;
  logic [DW-1:0] fwd_exmem_data;
  logic          fwd_memwb_en;
  logic [RW-1:0] fwd_memwb_rd;
  logic [DW-1:0] fwd_memwb_data;
  logic          out_valid;
  logic          out_is_shift;
  logic [DW-1:0] out_rs;
  logic [DW-1:0] out_imm;
  logic [1:0]    out_mode;
  logic [RW-1:0] out_rd;
  logic          out_wen;
  modport master (
    output in_valid, in_instr, in_rs_data, stall, flush,
           fwd_exmem_en, fwd_exmem_rd, fwd_exmem_data,
           fwd_memwb_en, fwd_memwb_rd, fwd_memwb_data,
    input  out_valid, out_is_shift, out_rs, out_imm, out_mode, out_rd, out_wen
  );
  modport slave (
    input  in_valid, in_instr, in_rs_data, stall, flush,
           fwd_exmem_en, fwd_exmem_rd, fwd_exmem_data,
           fwd_memwb_en, fwd_memwb_rd, fwd_memwb_data,
    output out_valid, out_is_shift, out_rs, out_imm, out_mode, out_rd, out_wen
  );
endinterface

// File: rtl/shift_id_ex_stage.sv
// shift_id_ex_stage: ID/EX register for SLL/SRA/ROR with two-level forwarding, stall hold and flush bubble
// SHIFT_STAGE_PERF_EN adds saturating perf_shift_cnt / perf_stall_cnt outputs.
module shift_id_ex_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  shift_id_ex_if.slave bus
`ifdef SHIFT_STAGE_PERF_EN
  ,
  output logic [15:0] perf_shift_cnt,
  output logic [15:0] perf_stall_cnt
`endif
);
  logic [3:0]    opc, imm;
  logic [RW-1:0] rd, rs;
  logic          dec_shift, ex_hit, wb_hit, snoop;
  logic [1:0]    dec_mode;
  logic [DW-1:0] fwd_rs;
  logic          valid_q, valid_d, is_shift_q, is_shift_d, wen_q, wen_d;
  logic [DW-1:0] rs_q, rs_d;
  logic [3:0]    imm_q, imm_d;
  logic [1:0]    mode_q, mode_d;
  logic [RW-1:0] rd_q, rd_d, rsa_q, rsa_d;
  always_comb begin
    opc        = bus.in_instr[15:12];
    rd         = bus.in_instr[11:8];
    rs         = bus.in_instr[7:4];
    imm        = bus.in_instr[3:0];
    dec_shift  = opc == 4'h4 || opc == 4'h5 || opc == 4'h6;
    dec_mode   = opc == 4'h5 ? 2'b01 : opc == 4'h6 ? 2'b10 : 2'b00;
    ex_hit     = bus.fwd_exmem_en && bus.fwd_exmem_rd == rs && rs != '0;
    wb_hit     = bus.fwd_memwb_en && bus.fwd_memwb_rd == rs && rs != '0;
    fwd_rs     = ex_hit ? bus.fwd_exmem_data : wb_hit ? bus.fwd_memwb_data : bus.in_rs_data;
    // a producer retiring from MEM/WB while we are held must still reach the shifter
    snoop      = bus.fwd_memwb_en && bus.fwd_memwb_rd == rsa_q && rsa_q != '0 && valid_q;
    valid_d    = bus.flush ? 1'b0 : bus.stall ? valid_q    : bus.in_valid;
    is_shift_d = bus.flush ? 1'b0 : bus.stall ? is_shift_q : dec_shift;
    wen_d      = bus.flush ? 1'b0 : bus.stall ? wen_q      : bus.in_valid && dec_shift && rd != '0;
    mode_d     = bus.flush ? '0   : bus.stall ? mode_q     : dec_mode;
    imm_d      = bus.flush ? '0   : bus.stall ? imm_q      : imm;
    rd_d       = bus.flush ? '0   : bus.stall ? rd_q       : rd;
    rsa_d      = bus.flush ? '0   : bus.stall ? rsa_q      : rs;
    rs_d       = bus.flush ? '0   : bus.stall ? (snoop ? bus.fwd_memwb_data : rs_q) : fwd_rs;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      is_shift_q <= 1'b0;
      wen_q      <= 1'b0;
      rs_q       <= '0;
      imm_q      <= '0;
      mode_q     <= '0;
      rd_q       <= '0;
      rsa_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      is_shift_q <= is_shift_d;
      wen_q      <= wen_d;
      rs_q       <= rs_d;
      imm_q      <= imm_d;
      mode_q     <= mode_d;
      rd_q       <= rd_d;
      rsa_q      <= rsa_d;
    end
  end
  assign bus.out_valid    = valid_q;
  assign bus.out_is_shift = is_shift_q;
  assign bus.out_wen      = wen_q;
  assign bus.out_rs       = rs_q;
  assign bus.out_imm      = {{(DW-4){1'b0}}, imm_q};
  assign bus.out_mode     = mode_q;
  assign bus.out_rd       = rd_q;
`ifdef SHIFT_STAGE_PERF_EN
  logic [15:0] shift_cnt_q, shift_cnt_d, stall_cnt_q, stall_cnt_d;
  always_comb begin
    shift_cnt_d = (!bus.flush && !bus.stall && bus.in_valid && dec_shift && shift_cnt_q != 16'hFFFF)
                  ? shift_cnt_q + 16'd1 : shift_cnt_q;
    stall_cnt_d = (!bus.flush && bus.stall && valid_q && stall_cnt_q != 16'hFFFF)
                  ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      shift_cnt_q <= shift_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign perf_shift_cnt = shift_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_shift_id_ex_stage.sv
// tb_shift_id_ex_stage: scoreboard bench with a spec-level reference model of the shift ID/EX stage
module tb_shift_id_ex_stage;
  typedef struct packed {
    logic        valid;
    logic        is_shift;
    logic [15:0] rs;
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [3:0]  rd;
    logic        wen;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;
  exp_t m;
  logic [3:0] m_rsa;
  exp_t sb[$];
  shift_id_ex_if bus ();
`ifdef SHIFT_STAGE_PERF_EN
  logic [15:0] perf_shift_cnt, perf_stall_cnt;
`endif
  shift_id_ex_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef SHIFT_STAGE_PERF_EN
    ,
    .perf_shift_cnt(perf_shift_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic set_in(input logic v, input logic [15:0] ins, input logic [15:0] rsd,
                        input logic st, input logic fl,
                        input logic xe, input logic [3:0] xr, input logic [15:0] xd,
                        input logic we, input logic [3:0] wr, input logic [15:0] wd);
    bus.in_valid = v; bus.in_instr = ins; bus.in_rs_data = rsd;
    bus.stall = st; bus.flush = fl;
    bus.fwd_exmem_en = xe; bus.fwd_exmem_rd = xr; bus.fwd_exmem_data = xd;
    bus.fwd_memwb_en = we; bus.fwd_memwb_rd = wr; bus.fwd_memwb_data = wd;
  endtask
  // reference: what the stage must hold after the coming edge, from the current inputs
  task automatic step();
    exp_t n;
    logic [3:0] op, rs;
    op = bus.in_instr[15:12];
    rs = bus.in_instr[7:4];
    n = m;
    if (bus.flush) begin
      n = '0;
      m_rsa = 4'd0;
    end else if (bus.stall) begin
      if (bus.fwd_memwb_en && bus.fwd_memwb_rd == m_rsa && m_rsa != 4'd0 && m.valid)
        n.rs = bus.fwd_memwb_data;
    end else begin
      case (op)
        4'h4: begin n.is_shift = 1'b1; n.mode = 2'd0; end
        4'h5: begin n.is_shift = 1'b1; n.mode = 2'd1; end
        4'h6: begin n.is_shift = 1'b1; n.mode = 2'd2; end
        default: begin n.is_shift = 1'b0; n.mode = 2'd0; end
      endcase
      n.valid = bus.in_valid;
      n.rd    = bus.in_instr[11:8];
      n.imm   = {12'd0, bus.in_instr[3:0]};
      n.wen   = bus.in_valid && n.is_shift && n.rd != 4'd0;
      if (bus.fwd_exmem_en && bus.fwd_exmem_rd == rs && rs != 4'd0) n.rs = bus.fwd_exmem_data;
      else if (bus.fwd_memwb_en && bus.fwd_memwb_rd == rs && rs != 4'd0) n.rs = bus.fwd_memwb_data;
      else n.rs = bus.in_rs_data;
      m_rsa = rs;
    end
    m = n;
    sb.push_back(n);
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    sb.delete();
    m = '0;
    m_rsa = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (sb.size() == 0) chk("sb_underflow", 16'd1, 16'd0);
        else begin
          e = sb.pop_front();
          chk("valid", 16'(bus.out_valid), 16'(e.valid));
          chk("is_shift", 16'(bus.out_is_shift), 16'(e.is_shift));
          chk("rs", bus.out_rs, e.rs);
          chk("imm", bus.out_imm, e.imm);
          chk("mode", 16'(bus.out_mode), 16'(e.mode));
          chk("rd", 16'(bus.out_rd), 16'(e.rd));
          chk("wen", 16'(bus.out_wen), 16'(e.wen));
        end
      end
    end
  end
  initial begin
    logic [3:0] op;
    rst_n = 1'b0;
    m = '0;
    m_rsa = 4'd0;
    set_in(0, 16'h0, 16'h0, 0, 0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    #12;
    chk("rst_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_rs", bus.out_rs, 16'd0);
    chk("rst_wen", 16'(bus.out_wen), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    set_in(1, 16'h5237, 16'h8001, 0, 0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    step();
    chk("sra_mode", 16'(bus.out_mode), 16'd1);
    chk("sra_imm", bus.out_imm, 16'h0007);
    chk("sra_rs", bus.out_rs, 16'h8001);
    chk("sra_rd", 16'(bus.out_rd), 16'd2);
    chk("sra_wen", 16'(bus.out_wen), 16'd1);
    set_in(1, 16'h4115, 16'h1111, 1, 0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    step();
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 16'(bus.out_valid), 16'd0);
    chk("arst_mode", 16'(bus.out_mode), 16'd0);
    chk("arst_rs", bus.out_rs, 16'd0);
    chk("arst_imm", bus.out_imm, 16'd0);
    chk("arst_rd", 16'(bus.out_rd), 16'd0);
    chk("arst_wen", 16'(bus.out_wen), 16'd0);
    do_reset();
    set_in(1, 16'h4135, 16'h0F0F, 0, 0, 1, 4'd3, 16'hAAAA, 1, 4'd3, 16'h5555);
    step();
    chk("fwd_exmem_prio", bus.out_rs, 16'hAAAA);
    set_in(1, 16'h4135, 16'h0F0F, 0, 0, 0, 4'd3, 16'hAAAA, 1, 4'd3, 16'h5555);
    step();
    chk("fwd_memwb", bus.out_rs, 16'h5555);
    set_in(1, 16'h4105, 16'h0F0F, 0, 0, 1, 4'd0, 16'hAAAA, 1, 4'd0, 16'h5555);
    step();
    chk("fwd_r0", bus.out_rs, 16'h0F0F);
    set_in(1, 16'h6143, 16'h0F0F, 0, 0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    step();
    set_in(0, 16'h0, 16'h0, 1, 0, 0, 4'd0, 16'h0, 0, 4'd4, 16'h1234);
    step();
    chk("snoop_c1_rs", bus.out_rs, 16'h0F0F);
    set_in(0, 16'h0, 16'h0, 1, 0, 0, 4'd0, 16'h0, 1, 4'd4, 16'h1234);
    step();
    chk("snoop_c2_rs", bus.out_rs, 16'h1234);
    set_in(0, 16'h0, 16'h0, 1, 0, 0, 4'd0, 16'h0, 0, 4'd4, 16'h9999);
    step();
    chk("snoop_c3_rs", bus.out_rs, 16'h1234);
    chk("snoop_mode", 16'(bus.out_mode), 16'd2);
    set_in(1, 16'h4115, 16'h2222, 1, 1, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    step();
    chk("flush_valid", 16'(bus.out_valid), 16'd0);
    chk("flush_wen", 16'(bus.out_wen), 16'd0);
    set_in(1, 16'h1123, 16'h3333, 0, 0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    step();
    chk("nonshift_valid", 16'(bus.out_valid), 16'd1);
    chk("nonshift_is", 16'(bus.out_is_shift), 16'd0);
    chk("nonshift_wen", 16'(bus.out_wen), 16'd0);
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(4, 6));
      set_in(1'($urandom_range(0, 3) != 0),
             {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom)},
             16'($urandom),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom));
      step();
    end
`ifdef SHIFT_STAGE_PERF_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 16'h5213, 16'($urandom), 0, 0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      set_in(1, 16'h5213, 16'h0, 1, 0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
      step();
    end
    chk("perf_shift_5", perf_shift_cnt, 16'd5);
    chk("perf_stall_2", perf_stall_cnt, 16'd2);
    for (int i = 0; i < 65530; i++) begin
      set_in(1, 16'h4213, 16'h0, 0, 0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
      step();
    end
    chk("perf_shift_max", perf_shift_cnt, 16'hFFFF);
    step();
    chk("perf_shift_sat", perf_shift_cnt, 16'hFFFF);
`endif
    set_in(0, 16'h0, 16'h0, 0, 0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
